pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register, successor to the fixed ID/EX latch.
//  Carries inst, inst_addr and a generic PAYLOAD_W-bit side-band between any two stages.
//  Uses a valid/ready handshake with a 2-entry skid, so a downstream stall never drops data
//  and in_ready is a pure register output. flush_en squashes all held entries to NOP bubbles.
// PARAMETERS
//  PAYLOAD_W  138  width of side-band bus (default = op1,op2,rd_addr,rd_wen,base,offset)
//  CNT_W      16   width of perf counters (used only with PIPE_PERF_EN)
// PORTS
//  sys_clk      in   1          single clock, rising edge
//  sys_rst_n    in   1          asynchronous, active-low reset
//  flush_en     in   1          synchronous squash of all held entries
//  in_valid     in   1          upstream entry valid
//  in_ready     out  1          stage can accept; registered
//  in_inst      in   32         instruction word
//  in_inst_addr in   32         instruction address
//  in_payload   in   PAYLOAD_W  side-band operands/control
//  out_valid    out  1          output entry valid
//  out_ready    in   1          downstream accepts
//  out_inst     out  32         INST_NOP when !out_valid
//  out_inst_addr out 32         0 when !out_valid
//  out_payload  out  PAYLOAD_W  0 when !out_valid
//  stall_cnt    out  CNT_W      (PIPE_PERF_EN only) cycles with out_valid & !out_ready
//  flush_cnt    out  CNT_W      (PIPE_PERF_EN only) cycles with flush_en high
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - States: EMPTY (no entry), ONE (main slot full), TWO (main + skid full).
//    out_valid = (state != EMPTY); in_ready = (state != TWO); both decode registered state.
//  - Reset (async): state=EMPTY, both slots inst=INST_NOP, addr/payload=0, in_ready=1, counters=0.
//  - EMPTY: in_fire -> main<=in, ONE.
//  - ONE: in_fire & out_ready -> main<=in, stay ONE; in_fire & !out_ready -> skid<=in, TWO;
//    !in_fire & out_ready -> EMPTY; else hold.
//  - TWO: out_ready -> main<=skid, ONE; else hold. No in_fire is possible (in_ready=0).
//  - Latency: 1 cycle from in_fire to out_valid when downstream is not stalled; throughput 1/cycle.
//  - Order is strictly FIFO: skid is never presented before main.
//  - flush_en has priority over every transition: next state=EMPTY, both slots cleared to
//    NOP/0, and an in_fire in the same cycle is discarded. in_ready is 1 the following cycle.
//  - An out_fire coinciding with flush_en counts as delivered; downstream owns its own squash.
//  - Outputs come straight from the main slot register: no combinational in->out path,
//    and no combinational out_ready->in_ready path.
//  - An in-flight entry is lost on reset; no partial state survives.
// CONFIGURATION
//  - PIPE_PERF_EN defined: stall_cnt and flush_cnt ports exist. Each increments per qualifying
//    cycle, saturates at all-ones and clears only on reset.
//  - PIPE_PERF_EN undefined: counter ports and logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  - defines.v holds INST_NOP and the state encodings: PSR_EMPTY=2'd0, PSR_ONE=2'd1, PSR_TWO=2'd2.
//  - Sub-module pipe_slot_reg is instantiated twice (main, skid).
//    It is a {inst,addr,payload} register with load, and clear-to-NOP on async reset or sync clr.
//  - Top holds only the FSM, the slot muxing and the optional counters.
// TESTING
//  - Stream: in_valid=1 with 4 entries, out_ready=1 -> out matches in 1 cycle later,
//    in_ready stays 1, no bubbles.
//  - Stall: out_ready=0 after entry A, then send B -> state TWO, in_ready=0, C held off;
//    on out_ready=1 outputs A then B, in order.
//  - Flush in TWO: flush_en=1 with in_valid=1 (entry C) -> next cycle out_valid=0,
//    out_inst=INST_NOP, in_ready=1; C never appears at the output.
//  - Mid-op reset: sys_rst_n low while in ONE -> out_valid=0 and out_inst=INST_NOP immediately,
//    without waiting for a clock edge.
//  - PAYLOAD_W=8: payload 8'hA5 passes intact; idle payload reads 0.
//  - PIPE_PERF_EN, CNT_W=4: 20 stall cycles -> stall_cnt=4'hF (saturated); 3 flush cycles -> flush_cnt=3.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline stage register: NOP encoding and FSM state encodings.
package pipe_stage_reg_pkg;

   // RISC-V canonical NOP (addi x0, x0, 0); held slots show this when empty.
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   // Occupancy of the stage: nothing, main slot only, main plus skid slot.
   typedef enum logic [1:0] {
      PSR_EMPTY = 2'd0,
      PSR_ONE   = 2'd1,
      PSR_TWO   = 2'd2
   } psr_state_e;

endpackage

// File: rtl/pipe_slot_reg.sv
// One held pipeline entry {inst, addr, payload}. Clear wins over load; clear and reset
// both return the slot to a NOP bubble with zeroed address and payload.
module pipe_slot_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int PAYLOAD_W = 138
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 clr_i,
   input  logic                 load_i,
   input  logic [31:0]          inst_i,
   input  logic [31:0]          addr_i,
   input  logic [PAYLOAD_W-1:0] payload_i,
   output logic [31:0]          inst_o,
   output logic [31:0]          addr_o,
   output logic [PAYLOAD_W-1:0] payload_o
);

   logic [31:0]          inst_q;
   logic [31:0]          addr_q;
   logic [PAYLOAD_W-1:0] payload_q;

   // Entry storage: squash to NOP on clear, capture on load, otherwise hold.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         inst_q    <= INST_NOP;
         addr_q    <= '0;
         payload_q <= '0;
      end else if (clr_i) begin
         inst_q    <= INST_NOP;
         addr_q    <= '0;
         payload_q <= '0;
      end else if (load_i) begin
         inst_q    <= inst_i;
         addr_q    <= addr_i;
         payload_q <= payload_i;
      end
   end

   assign inst_o    = inst_q;
   assign addr_o    = addr_q;
   assign payload_o = payload_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage with a 2-entry skid (main + skid slot).
// Outputs are driven directly by the main slot, which is cleared whenever it is not
// holding a valid entry, so an idle stage shows a NOP bubble with zero address/payload.
// in_ready and out_valid are registered decodes of the occupancy state.
// Optional feature: define PIPE_PERF_EN to add saturating stall_cnt / flush_cnt counters.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int PAYLOAD_W = 138,
   parameter int CNT_W     = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 flush_en,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_inst,
   input  logic [31:0]          in_inst_addr,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_inst,
   output logic [31:0]          out_inst_addr,
   output logic [PAYLOAD_W-1:0] out_payload
`ifdef PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
`endif
);

   psr_state_e state_q, state_d;
   logic       in_ready_q;
   logic       out_valid_q;
   logic       in_fire;

   logic       main_load, main_clr, main_from_skid;
   logic       skid_load, skid_clr;

   logic [31:0]          main_inst_d, main_addr_d;
   logic [PAYLOAD_W-1:0] main_payload_d;
   logic [31:0]          main_inst_q, main_addr_q;
   logic [PAYLOAD_W-1:0] main_payload_q;
   logic [31:0]          skid_inst_q, skid_addr_q;
   logic [PAYLOAD_W-1:0] skid_payload_q;

   assign in_fire = in_valid & in_ready_q;

   // Next occupancy and slot control; flush overrides every transition and drops in_fire.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (flush_en) begin
         state_d  = PSR_EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         unique case (state_q)
            PSR_EMPTY: begin
               if (in_fire) begin
                  main_load = 1'b1;
                  state_d   = PSR_ONE;
               end
            end
            PSR_ONE: begin
               if (in_fire && out_ready) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  skid_load = 1'b1;
                  state_d   = PSR_TWO;
               end else if (out_ready) begin
                  // Main entry delivered with nothing behind it: leave a bubble.
                  main_clr = 1'b1;
                  state_d  = PSR_EMPTY;
               end
            end
            PSR_TWO: begin
               if (out_ready) begin
                  // Older entry leaves, skid entry moves up to keep FIFO order.
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_d        = PSR_ONE;
               end
            end
            default: begin
               state_d  = PSR_EMPTY;
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   // Occupancy state plus its registered handshake decodes.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= PSR_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != PSR_TWO);
         out_valid_q <= (state_d != PSR_EMPTY);
      end
   end

   // Main slot loads either from upstream or from the skid slot.
   always_comb begin
      main_inst_d    = in_inst;
      main_addr_d    = in_inst_addr;
      main_payload_d = in_payload;
      if (main_from_skid) begin
         main_inst_d    = skid_inst_q;
         main_addr_d    = skid_addr_q;
         main_payload_d = skid_payload_q;
      end
   end

   pipe_slot_reg #(.PAYLOAD_W(PAYLOAD_W)) u_main (
      .clk_i     (sys_clk),
      .rst_n_i   (sys_rst_n),
      .clr_i     (main_clr),
      .load_i    (main_load),
      .inst_i    (main_inst_d),
      .addr_i    (main_addr_d),
      .payload_i (main_payload_d),
      .inst_o    (main_inst_q),
      .addr_o    (main_addr_q),
      .payload_o (main_payload_q)
   );

   pipe_slot_reg #(.PAYLOAD_W(PAYLOAD_W)) u_skid (
      .clk_i     (sys_clk),
      .rst_n_i   (sys_rst_n),
      .clr_i     (skid_clr),
      .load_i    (skid_load),
      .inst_i    (in_inst),
      .addr_i    (in_inst_addr),
      .payload_i (in_payload),
      .inst_o    (skid_inst_q),
      .addr_o    (skid_addr_q),
      .payload_o (skid_payload_q)
   );

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_inst      = main_inst_q;
   assign out_inst_addr = main_addr_q;
   assign out_payload   = main_payload_q;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Saturating event counters; only reset clears them.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush_en && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   // Counter width is only meaningful when the counters are built.
   wire [CNT_W-1:0] unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (PAYLOAD_W=8, CNT_W=4). Counter checks are built
// when PIPE_PERF_EN is defined.
module tb_pipe_stage_reg;
   import pipe_stage_reg_pkg::*;

   localparam int PW = 8;
   localparam int CW = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          flush_en = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_inst = '0;
   logic [31:0]   in_inst_addr = '0;
   logic [PW-1:0] in_payload = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_inst;
   logic [31:0]   out_inst_addr;
   logic [PW-1:0] out_payload;
`ifdef PIPE_PERF_EN
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 sys_clk = ~sys_clk;

   pipe_stage_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .flush_en      (flush_en),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_inst       (in_inst),
      .in_inst_addr  (in_inst_addr),
      .in_payload    (in_payload),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_inst_addr (out_inst_addr),
      .out_payload   (out_payload)
`ifdef PIPE_PERF_EN
      ,
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
`endif
   );

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [PW-1:0] p);
      in_valid = v; in_inst = i; in_inst_addr = a; in_payload = p;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b0; flush_en = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, '0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      n_cmp++; if (out_inst !== NOP) begin n_err++; $display("FAIL reset_out_inst got %h want %h", out_inst, NOP); end
      n_cmp++; if (out_inst_addr !== 32'h0) begin n_err++; $display("FAIL reset_out_addr got %h want 0", out_inst_addr); end
      n_cmp++; if (out_payload !== 8'h00) begin n_err++; $display("FAIL reset_out_payload got %h want 00", out_payload); end
      $display("reset: out_valid=%0b in_ready=%0b out_inst=%h", out_valid, in_ready, out_inst);
   endtask

   task automatic test_stream();
      logic [31:0]   insts [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};
      logic [31:0]   addrs [4] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
      logic [PW-1:0] pays  [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, insts[k], addrs[k], pays[k]);
         tick();
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0b want 1", k, out_valid); end
         n_cmp++; if (out_inst !== insts[k]) begin n_err++; $display("FAIL stream_inst[%0d] got %h want %h", k, out_inst, insts[k]); end
         n_cmp++; if (out_inst_addr !== addrs[k]) begin n_err++; $display("FAIL stream_addr[%0d] got %h want %h", k, out_inst_addr, addrs[k]); end
         n_cmp++; if (out_payload !== pays[k]) begin n_err++; $display("FAIL stream_payload[%0d] got %h want %h", k, out_payload, pays[k]); end
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got %0b want 1", k, in_ready); end
         $display("stream[%0d]: out_inst=%h addr=%h payload=%h", k, out_inst, out_inst_addr, out_payload);
      end
      drive(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 8'h77);
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %0b want 0", out_valid); end
      n_cmp++; if (out_inst !== NOP) begin n_err++; $display("FAIL idle_inst got %h want %h", out_inst, NOP); end
      n_cmp++; if (out_payload !== 8'h00) begin n_err++; $display("FAIL idle_payload got %h want 00", out_payload); end
      $display("stream idle: out_valid=%0b out_inst=%h payload=%h", out_valid, out_inst, out_payload);
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      drive(1'b1, 32'hAAAA_0001, 32'h0000_2000, 8'h11);   // A
      tick();
      n_cmp++; if (out_inst !== 32'hAAAA_0001) begin n_err++; $display("FAIL stall_A_first got %h want aaaa0001", out_inst); end
      drive(1'b1, 32'hBBBB_0002, 32'h0000_2004, 8'h22);   // B
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_two_in_ready got %0b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_two_valid got %0b want 1", out_valid); end
      n_cmp++; if (out_inst !== 32'hAAAA_0001) begin n_err++; $display("FAIL stall_two_inst got %h want aaaa0001", out_inst); end
      drive(1'b1, 32'hCCCC_0003, 32'h0000_2008, 8'h33);   // C, held off
      tick();
      n_cmp++; if (out_inst !== 32'hAAAA_0001) begin n_err++; $display("FAIL stall_hold_inst got %h want aaaa0001", out_inst); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_hold_in_ready got %0b want 0", in_ready); end
      drive(1'b0, 32'h0, 32'h0, '0);
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_inst !== 32'hBBBB_0002) begin n_err++; $display("FAIL stall_drain_B got %h want bbbb0002", out_inst); end
      n_cmp++; if (out_payload !== 8'h22) begin n_err++; $display("FAIL stall_drain_B_payload got %h want 22", out_payload); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_drain_in_ready got %0b want 1", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b0 || out_inst !== NOP) begin n_err++; $display("FAIL stall_no_C got valid=%0b inst=%h want 0/%h", out_valid, out_inst, NOP); end
      $display("stall: drained A then B, final out_valid=%0b", out_valid);
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 32'hAAAA_0011, 32'h0000_3000, 8'h44);
      tick();
      drive(1'b1, 32'hBBBB_0012, 32'h0000_3004, 8'h55);
      tick();
      drive(1'b1, 32'hCCCC_0013, 32'h0000_3008, 8'h66);
      flush_en = 1'b1;
      tick();
      flush_en = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_two_valid got %0b want 0", out_valid); end
      n_cmp++; if (out_inst !== NOP) begin n_err++; $display("FAIL flush_two_inst got %h want %h", out_inst, NOP); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_two_in_ready got %0b want 1", in_ready); end
      $display("flush in TWO: out_valid=%0b out_inst=%h in_ready=%0b", out_valid, out_inst, in_ready);
      // Flush in ONE with an accepted-looking input: the input must be dropped.
      drive(1'b1, 32'hAAAA_0021, 32'h0000_3010, 8'h77);
      tick();
      drive(1'b1, 32'hDDDD_0022, 32'h0000_3014, 8'h88);
      flush_en = 1'b1;
      tick();
      flush_en = 1'b0;
      drive(1'b0, 32'h0, 32'h0, '0);
      n_cmp++; if (out_valid !== 1'b0 || out_inst_addr !== 32'h0) begin n_err++; $display("FAIL flush_one_drop got valid=%0b addr=%h want 0/0", out_valid, out_inst_addr); end
      tick();
      n_cmp++; if (out_valid !== 1'b0 || out_inst !== NOP) begin n_err++; $display("FAIL flush_after got valid=%0b inst=%h want 0/%h", out_valid, out_inst, NOP); end
      $display("flush in ONE: input dropped, out_valid=%0b", out_valid);
   endtask

   task automatic test_midop_reset();
      out_ready = 1'b0;
      drive(1'b1, 32'h1234_5678, 32'h0000_4000, 8'h99);
      tick();
      drive(1'b0, 32'h0, 32'h0, '0);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got %0b want 1", out_valid); end
      #2 sys_rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
      n_cmp++; if (out_inst !== NOP) begin n_err++; $display("FAIL midrst_inst got %h want %h", out_inst, NOP); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
      $display("mid-op reset: out_valid=%0b out_inst=%h", out_valid, out_inst);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

`ifdef PIPE_PERF_EN
   task automatic test_perf();
      do_reset();
      n_cmp++; if (stall_cnt !== 4'h0 || flush_cnt !== 4'h0) begin n_err++; $display("FAIL perf_reset got %h/%h want 0/0", stall_cnt, flush_cnt); end
      out_ready = 1'b0;
      drive(1'b1, 32'h5555_0001, 32'h0000_5000, 8'h01);
      tick();
      drive(1'b0, 32'h0, 32'h0, '0);
      for (int k = 0; k < 3; k++) tick();
      n_cmp++; if (stall_cnt !== 4'h3) begin n_err++; $display("FAIL perf_stall3 got %h want 3", stall_cnt); end
      for (int k = 0; k < 17; k++) tick();
      n_cmp++; if (stall_cnt !== 4'hF) begin n_err++; $display("FAIL perf_stall_sat got %h want f", stall_cnt); end
      flush_en = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      flush_en = 1'b0;
      tick();
      n_cmp++; if (flush_cnt !== 4'h3) begin n_err++; $display("FAIL perf_flush3 got %h want 3", flush_cnt); end
      n_cmp++; if (stall_cnt !== 4'hF) begin n_err++; $display("FAIL perf_stall_hold got %h want f", stall_cnt); end
      $display("perf: stall_cnt=%h flush_cnt=%h", stall_cnt, flush_cnt);
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_midop_reset();
      test_reset();
`ifdef PIPE_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
